branch_predictor_fetch: RTL and testbench

//  Fetch-side branch predictor. It produces predicted_taken/predicted_target for the PC in the fetch stage.

---
 rtl/branch_predictor_fetch.sv | 111 +++++++++++
 tb/tb_branch_predictor_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_fetch.sv
// branch_predictor_fetch
//   Fetch-side branch predictor: a direct-mapped table of 2-bit saturating
//   counters (BHT) plus a tagged branch target buffer (BTB). Lookup is
//   combinational from current state. Execute trains the tables one edge later.
//   Also keeps saturating counts of resolved branches and mispredicts.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous active-high reset
//   pc_f                fetch-stage PC to predict
//   predicted_taken_f   prediction for pc_f (combinational)
//   predicted_target_f  next PC for pc_f (combinational)
//   update_valid_e      a branch resolved in execute this cycle
//   update_pc_e         PC of the resolved branch
//   update_taken_e      actual outcome
//   update_target_e     actual taken target
//   mispredict_e        execute flagged a mispredict (qualified by update_valid_e)
//   branch_count        resolved branches since reset, saturating
//   mispredict_count    mispredicts since reset, saturating
module branch_predictor_fetch #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        predicted_taken_f,
  output logic [31:0] predicted_target_f,
  input  logic        update_valid_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  input  logic        mispredict_e,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [1:0]          bht       [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid;
  logic [TAG_BITS-1:0] btb_tag   [ENTRIES];
  logic [31:0]         btb_tgt   [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0]   tag_f;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  lookup_hit;
  logic                  unused_upd_align;

  assign idx_f = pc_f[INDEX_BITS+1:2];
  assign tag_f = pc_f[31:INDEX_BITS+2];
  assign idx_e = update_pc_e[INDEX_BITS+1:2];
  assign tag_e = update_pc_e[31:INDEX_BITS+2];

  // Branch PCs are word aligned; the low bits carry no information here.
  assign unused_upd_align = ^update_pc_e[1:0];

  // Lookup reads the registered tables directly, so an update landing at the
  // same edge is not seen until the following cycle (no bypass).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch cannot be inferred.
    lookup_hit         = 1'b0;
    predicted_taken_f  = 1'b0;
    predicted_target_f = pc_f + 32'd4;
    lookup_hit         = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
    predicted_taken_f  = lookup_hit && bht[idx_f][1];
    if (predicted_taken_f) begin
      predicted_target_f = btb_tgt[idx_f];
    end
  end

  // Counters, valid bits and statistics: these carry reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= CNT_INIT;
      end
      btb_valid        <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid_e) begin
      if (update_taken_e) begin
        if (bht[idx_e] != 2'b11) bht[idx_e] <= bht[idx_e] + 2'd1;
        btb_valid[idx_e] <= 1'b1;
      end else begin
        if (bht[idx_e] != 2'b00) bht[idx_e] <= bht[idx_e] - 2'd1;
      end
      if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (mispredict_e && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

  // NOTE: tag and target arrays are deliberately not reset; a cleared valid
  // bit masks them, and leaving them reset-free lets them map to plain RAM.
  // Reset still gates the write so an update coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && update_valid_e && update_taken_e) begin
      btb_tag[idx_e] <= tag_e;
      btb_tgt[idx_e] <= update_target_e;
    end
  end

endmodule

// File: tb/tb_branch_predictor_fetch.sv
// Self-checking bench for branch_predictor_fetch: directed scenarios followed
// by randomized traffic, all compared against a behavioural table model.
module tb_branch_predictor_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        predicted_taken_f;
  logic [31:0] predicted_target_f;
  logic        update_valid_e;
  logic [31:0] update_pc_e;
  logic        update_taken_e;
  logic [31:0] update_target_e;
  logic        mispredict_e;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .pc_f               (pc_f),
    .predicted_taken_f  (predicted_taken_f),
    .predicted_target_f (predicted_target_f),
    .update_valid_e     (update_valid_e),
    .update_pc_e        (update_pc_e),
    .update_taken_e     (update_taken_e),
    .update_target_e    (update_target_e),
    .mispredict_e       (mispredict_e),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: counter value 0..3, taken when >= 2.
  int          m_cnt   [64];
  bit          m_valid [64];
  bit [31:0]   m_pc    [64];
  bit [31:0]   m_tgt   [64];
  longint      m_bcnt;
  longint      m_mcnt;

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_cnt[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // Captured observations from the most recent step, for directed checks.
  logic        last_taken;
  logic [31:0] last_target;
  logic [31:0] last_bcnt;
  logic [31:0] last_mcnt;

  // One cycle: drive inputs, compare lookup and counts against the model
  // (pre-edge state), clock, then advance the model.
  task automatic step(input bit r, input bit [31:0] pc, input bit uv, input bit [31:0] upc,
                      input bit ut, input bit [31:0] utgt, input bit mp);
    int          i;
    bit          hit;
    bit          exp_taken;
    bit [31:0]   exp_target;
    rst = r; pc_f = pc; update_valid_e = uv; update_pc_e = upc;
    update_taken_e = ut; update_target_e = utgt; mispredict_e = mp;
    #1;
    i          = idx_of(pc);
    hit        = m_valid[i] && ((m_pc[i] >> 8) == (pc >> 8));
    exp_taken  = hit && (m_cnt[i] >= 2);
    exp_target = exp_taken ? m_tgt[i] : pc + 32'd4;
    check("taken",  {31'd0, predicted_taken_f}, {31'd0, exp_taken});
    check("target", predicted_target_f, exp_target);
    check("bcnt",   branch_count,     m_bcnt > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_bcnt[31:0]);
    check("mcnt",   mispredict_count, m_mcnt > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_mcnt[31:0]);
    last_taken  = predicted_taken_f;
    last_target = predicted_target_f;
    last_bcnt   = branch_count;
    last_mcnt   = mispredict_count;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (uv) begin
      i = idx_of(upc);
      if (ut) begin
        if (m_cnt[i] < 3) m_cnt[i]++;
        m_valid[i] = 1'b1;
        m_pc[i]    = upc;
        m_tgt[i]   = utgt;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]--;
      end
      m_bcnt++;
      if (mp) m_mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic lookup(input bit [31:0] pc);
    step(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input bit [31:0] upc, input bit ut, input bit [31:0] utgt);
    step(1'b0, 32'h0, 1'b1, upc, ut, utgt, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h0; update_valid_e = 1'b0; update_pc_e = 32'h0;
    update_taken_e = 1'b0; update_target_e = 32'h0; mispredict_e = 1'b0;
    // Unchecked initial reset: outputs are undefined until the first edge.
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // 1: reset state.
    lookup(32'h100);
    check("rst_taken",  {31'd0, last_taken}, 32'd0);
    check("rst_target", last_target, 32'h104);
    check("rst_bcnt",   last_bcnt,   32'd0);

    // 2: one taken update makes WT and fills the BTB.
    train(32'h100, 1'b1, 32'h40);
    lookup(32'h100);
    check("wt_taken",  {31'd0, last_taken}, 32'd1);
    check("wt_target", last_target, 32'h40);

    // 3: hysteresis from strongly taken.
    do_reset();
    for (int k = 0; k < 5; k++) train(32'h100, 1'b1, 32'h40);
    train(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    check("hyst1_taken", {31'd0, last_taken}, 32'd1);
    check("hyst1_target", last_target, 32'h40);
    train(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    check("hyst2_taken", {31'd0, last_taken}, 32'd0);
    check("hyst2_target", last_target, 32'h104);

    // 4: aliasing at the same index with a different tag.
    do_reset();
    train(32'h100, 1'b1, 32'h40);
    lookup(32'h200);
    check("alias_taken",  {31'd0, last_taken}, 32'd0);
    check("alias_target", last_target, 32'h204);
    train(32'h200, 1'b1, 32'h80);
    lookup(32'h100);
    check("evict_taken",  {31'd0, last_taken}, 32'd0);
    check("evict_target", last_target, 32'h104);
    lookup(32'h200);
    check("new_taken",  {31'd0, last_taken}, 32'd1);
    check("new_target", last_target, 32'h80);

    // 5: lookup and update of the same index in the same cycle.
    do_reset();
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0);
    check("same_cyc_taken", {31'd0, last_taken}, 32'd0);
    lookup(32'h100);
    check("next_cyc_taken", {31'd0, last_taken}, 32'd1);

    // 6: statistics, ignored mispredict, reset dominating an update.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(k * 4), k[0], 32'h2000, k < 3);
    end
    step(1'b0, 32'h0, 1'b0, 32'h100, 1'b1, 32'h40, 1'b1);
    lookup(32'h0);
    check("stat_bcnt", last_bcnt, 32'd10);
    check("stat_mcnt", last_mcnt, 32'd3);
    step(1'b1, 32'h0, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
    lookup(32'h100);
    check("rstupd_taken", {31'd0, last_taken}, 32'd0);
    check("rstupd_bcnt",  last_bcnt, 32'd0);
    check("rstupd_mcnt",  last_mcnt, 32'd0);

    // Randomized traffic over a small PC pool so indices alias and counters saturate.
    for (int k = 0; k < 3000; k++) begin
      bit [31:0] rpc;
      bit [31:0] upc;
      rpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      if (($urandom % 8) == 0) rpc = $urandom & 32'hFFFF_FFFC;
      step(($urandom % 128) == 0, rpc, $urandom_range(0, 3) != 0, upc,
           $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
